alarm_sequencer: RTL and testbench

Downstream stage of the alarm comparator. It turns the comparator's level-valued time/alarm match into a ringing session with a bounded ring time, a limited number of snoozes and a stop button. Its `ring` output drives the buzzer. The comparator's match stays high for the whole matching minute, so the sequencer triggers only on the rising edge of the match. A stopped alarm therefore does not re-ring within the same minute.

---
 rtl/alarm_seq_if.sv | 29 ++
 rtl/alarm_sequencer.sv | 156 +++++++++++++++
 tb/tb_alarm_sequencer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/alarm_seq_if.sv
// alarm_seq_if: bundles the alarm sequencer's control inputs and status outputs.
// master = upstream side (comparator, tick source, buttons); slave = the sequencer.
// Pulse semantics: sec_tick, snooze and stop are single-cycle pulses sampled on
// the rising clock edge; there is no backpressure and no ready signal.
// state is a read-only debug view of the sequencer FSM (0 idle, 1 ring, 2 snooze).
interface alarm_seq_if #(
  parameter int CNT_W = 2
) ();
  logic             sec_tick;
  logic             match;
  logic             alarm_en;
  logic             snooze;
  logic             stop;
  logic             ring;
  logic             snoozing;
  logic             missed;
  logic [CNT_W-1:0] snooze_cnt;
  logic [1:0]       state;

  modport master (
    output sec_tick, match, alarm_en, snooze, stop,
    input  ring, snoozing, missed, snooze_cnt, state
  );

  modport slave (
    input  sec_tick, match, alarm_en, snooze, stop,
    output ring, snoozing, missed, snooze_cnt, state
  );
endinterface

// File: rtl/alarm_sequencer.sv
// alarm_sequencer: turns the level-valued alarm match into a ringing session with
// bounded ring time, limited snoozes and a stop button. Triggers only on the
// rising edge of match, so a stopped alarm does not re-ring in the same minute.
// Optional feature macro ALARM_SEQ_BEEP_EN: when defined, ring beeps 1 s on /
// 1 s off while ringing (starting on); otherwise ring is steady high in RING.
module alarm_sequencer #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZES = 3
) (
  input logic        clk,
  input logic        rst_n,
  alarm_seq_if.slave bus
);

  localparam int MAX_T = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
  localparam int TW    = $clog2(MAX_T + 1);
  localparam int CNT_W = (MAX_SNOOZES < 1) ? 1 : $clog2(MAX_SNOOZES + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RING   = 2'd1,
    S_SNOOZE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             match_q;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             missed_q, missed_d;
  logic             ring_q, ring_d;
  logic             snoozing_q, snoozing_d;
`ifdef ALARM_SEQ_BEEP_EN
  logic             beep_q, beep_d;
`endif

  logic trig;
  logic timer_one;
  logic snooze_ok;

  assign trig      = bus.match & ~match_q & bus.alarm_en;
  assign timer_one = (timer_q == TW'(1));
  assign snooze_ok = (int'(cnt_q) < MAX_SNOOZES);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; priority order inside each state matters
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (trig) state_d = S_RING;
      end
      S_RING: begin
        if (!bus.alarm_en)                   state_d = S_IDLE;
        else if (bus.stop)                   state_d = S_IDLE;
        else if (bus.snooze && snooze_ok)    state_d = S_SNOOZE;
        else if (bus.sec_tick && timer_one)  state_d = S_IDLE;
      end
      S_SNOOZE: begin
        if (!bus.alarm_en)                   state_d = S_IDLE;
        else if (bus.stop)                   state_d = S_IDLE;
        else if (bus.sec_tick && timer_one)  state_d = S_RING;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values, driven by the FSM decision
  always_comb begin
    timer_d    = timer_q;
    cnt_d      = cnt_q;
    missed_d   = missed_q;
    // stop clears the missed flag in every state
    if (bus.stop) missed_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trig) begin
          timer_d  = TW'(RING_SECS);
          cnt_d    = '0;
          missed_d = 1'b0;
        end
      end
      S_RING: begin
        if (state_d == S_SNOOZE) begin
          timer_d = TW'(SNOOZE_SECS);
          cnt_d   = cnt_q + CNT_W'(1);
        end else if (state_d == S_IDLE) begin
          timer_d = '0;
          // only an unanswered timeout reaches IDLE while armed and not stopped
          if (bus.alarm_en && !bus.stop) missed_d = 1'b1;
        end else if (bus.sec_tick) begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_SNOOZE: begin
        if (state_d == S_RING) begin
          timer_d = TW'(RING_SECS);
        end else if (state_d == S_IDLE) begin
          timer_d = '0;
        end else if (bus.sec_tick) begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: timer_d = '0;
    endcase
    snoozing_d = (state_d == S_SNOOZE);
`ifdef ALARM_SEQ_BEEP_EN
    beep_d = beep_q;
    if (state_d == S_RING && state_q != S_RING) beep_d = 1'b1;
    else if (state_q == S_RING && bus.sec_tick)  beep_d = ~beep_q;
    ring_d = (state_d == S_RING) & beep_d;
`else
    ring_d = (state_d == S_RING);
`endif
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_q    <= 1'b0;
      timer_q    <= '0;
      cnt_q      <= '0;
      missed_q   <= 1'b0;
      ring_q     <= 1'b0;
      snoozing_q <= 1'b0;
`ifdef ALARM_SEQ_BEEP_EN
      beep_q     <= 1'b0;
`endif
    end else begin
      match_q    <= bus.match;
      timer_q    <= timer_d;
      cnt_q      <= cnt_d;
      missed_q   <= missed_d;
      ring_q     <= ring_d;
      snoozing_q <= snoozing_d;
`ifdef ALARM_SEQ_BEEP_EN
      beep_q     <= beep_d;
`endif
    end
  end

  assign bus.ring       = ring_q;
  assign bus.snoozing   = snoozing_q;
  assign bus.missed     = missed_q;
  assign bus.snooze_cnt = cnt_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// tb_alarm_sequencer: directed scenarios for alarm_sequencer with a session-level
// model (elapsed ticks per phase, snoozes used) feeding an expected queue.
module tb_alarm_sequencer;

  localparam int RING  = 5;
  localparam int SNZ   = 3;
  localparam int MAXS  = 2;
  localparam int CNT_W = 2;
`ifdef ALARM_SEQ_BEEP_EN
  localparam bit BEEP = 1'b1;
`else
  localparam bit BEEP = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  alarm_seq_if #(.CNT_W(CNT_W)) bus ();

  alarm_sequencer #(
    .RING_SECS  (RING),
    .SNOOZE_SECS(SNZ),
    .MAX_SNOOZES(MAXS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + scoreboard ----------------
  // expected vector: {ring, snoozing, missed, snooze_cnt}
  logic [4:0] exp_q[$];
  int m_mode;    // 0 idle, 1 ringing, 2 snoozing
  int m_ticks;   // ticks elapsed in the current ringing/snoozing phase
  int m_used;    // snoozes used this session
  bit m_missed;
  bit m_prev;

  always @(posedge clk or negedge rst_n) begin
    bit trig;
    bit ring_e;
    if (!rst_n) begin
      m_mode = 0; m_ticks = 0; m_used = 0; m_missed = 0; m_prev = 0;
      exp_q.delete();
      exp_q.push_back(5'b0);
    end else begin
      trig   = bus.match && !m_prev && bus.alarm_en;
      m_prev = bus.match;
      if (bus.stop) m_missed = 0;
      case (m_mode)
        0: if (trig) begin m_mode = 1; m_ticks = 0; m_used = 0; m_missed = 0; end
        1: begin
          if (!bus.alarm_en || bus.stop) m_mode = 0;
          else if (bus.snooze && m_used < MAXS) begin
            m_mode = 2; m_ticks = 0; m_used++;
          end else if (bus.sec_tick) begin
            m_ticks++;
            if (m_ticks == RING) begin m_mode = 0; m_missed = 1; end
          end
        end
        default: begin
          if (!bus.alarm_en || bus.stop) m_mode = 0;
          else if (bus.sec_tick) begin
            m_ticks++;
            if (m_ticks == SNZ) begin m_mode = 1; m_ticks = 0; end
          end
        end
      endcase
      // beeping: on during even-numbered seconds of the ringing phase
      ring_e = (m_mode == 1) && (!BEEP || (m_ticks % 2 == 0));
      exp_q.push_back({ring_e, m_mode == 2, m_missed, 2'(m_used)});
    end
  end

  // compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    logic [4:0] e;
    if (exp_q.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check("sb_ring",     int'(bus.ring),       int'(e[4]));
      check("sb_snoozing", int'(bus.snoozing),   int'(e[3]));
      check("sb_missed",   int'(bus.missed),     int'(e[2]));
      check("sb_cnt",      int'(bus.snooze_cnt), int'(e[1:0]));
    end
  end

  // ---------------- driver tasks ----------------
  // called at a negedge: hold the pulses for one cycle, then one quiet cycle
  task automatic pulse(input logic tk, input logic sz, input logic sp);
    bus.sec_tick = tk; bus.snooze = sz; bus.stop = sp;
    @(negedge clk);
    bus.sec_tick = 1'b0; bus.snooze = 1'b0; bus.stop = 1'b0;
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) pulse(1'b1, 1'b0, 1'b0);
  endtask

  task automatic rearm_match();
    bus.match = 1'b0;
    @(negedge clk);
    bus.match = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    bus.sec_tick = 1'b0; bus.match = 1'b0; bus.alarm_en = 1'b0;
    bus.snooze   = 1'b0; bus.stop  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ring",     int'(bus.ring),       0);
    check("rst_snoozing", int'(bus.snoozing),   0);
    check("rst_missed",   int'(bus.missed),     0);
    check("rst_cnt",      int'(bus.snooze_cnt), 0);
    rst_n = 1'b1;
    bus.alarm_en = 1'b1;
    @(negedge clk);

    // trigger and timeout
    bus.match = 1'b1;
    @(negedge clk);
    check("s1_ring_on", int'(bus.ring), 1);
    for (int i = 1; i <= 4; i++) begin
      pulse(1'b1, 1'b0, 1'b0);
      check("s1_ring_tick", int'(bus.ring), (BEEP && (i % 2 == 1)) ? 0 : 1);
    end
    pulse(1'b1, 1'b0, 1'b0);
    check("s1_timeout_ring",   int'(bus.ring),   0);
    check("s1_timeout_missed", int'(bus.missed), 1);
    repeat (4) @(negedge clk);
    check("s1_no_rering", int'(bus.ring), 0);
    pulse(1'b0, 1'b0, 1'b1);
    check("s1_stop_clears_missed", int'(bus.missed), 0);

    // snooze limit
    rearm_match();
    check("s2_ring_on", int'(bus.ring), 1);
    pulse(1'b0, 1'b1, 1'b0);
    check("s2_snoozing", int'(bus.snoozing),   1);
    check("s2_cnt1",     int'(bus.snooze_cnt), 1);
    check("s2_quiet",    int'(bus.ring),       0);
    ticks(2);
    check("s2_still_snoozing", int'(bus.snoozing), 1);
    ticks(1);
    check("s2_rering", int'(bus.ring), 1);
    pulse(1'b0, 1'b1, 1'b0);
    check("s2_cnt2", int'(bus.snooze_cnt), 2);
    ticks(3);
    check("s2_rering2", int'(bus.ring), 1);
    pulse(1'b0, 1'b1, 1'b0);
    check("s2_limit_ring",     int'(bus.ring),       1);
    check("s2_limit_snoozing", int'(bus.snoozing),   0);
    check("s2_limit_cnt",      int'(bus.snooze_cnt), 2);
    pulse(1'b0, 1'b0, 1'b1);
    check("s2_stop_ring",    int'(bus.ring),       0);
    check("s2_cnt_held_idle", int'(bus.snooze_cnt), 2);

    // stop wins over snooze
    rearm_match();
    pulse(1'b0, 1'b1, 1'b0);
    ticks(3);
    check("s3_ring", int'(bus.ring), 1);
    pulse(1'b0, 1'b1, 1'b1);
    check("s3_ring_off",  int'(bus.ring),       0);
    check("s3_snoozing",  int'(bus.snoozing),   0);
    check("s3_cnt_kept",  int'(bus.snooze_cnt), 1);

    // disarm during snooze, then re-trigger
    rearm_match();
    pulse(1'b0, 1'b1, 1'b0);
    check("s4_snoozing", int'(bus.snoozing), 1);
    bus.alarm_en = 1'b0;
    @(negedge clk);
    check("s4_disarm_snoozing", int'(bus.snoozing), 0);
    check("s4_disarm_ring",     int'(bus.ring),     0);
    bus.alarm_en = 1'b1;
    @(negedge clk);
    check("s4_level_no_trig", int'(bus.ring), 0);
    rearm_match();
    check("s4_new_ring", int'(bus.ring),       1);
    check("s4_new_cnt",  int'(bus.snooze_cnt), 0);
    // a fresh match edge while ringing must not restart the ring timer
    ticks(2);
    rearm_match();
    ticks(2);
    check("s4_no_restart", int'(bus.ring), 1);
    ticks(1);
    check("s4_timeout_ring",   int'(bus.ring),   0);
    check("s4_timeout_missed", int'(bus.missed), 1);

    // asynchronous reset mid-ring
    rearm_match();
    pulse(1'b0, 1'b1, 1'b0);
    ticks(3);
    check("s5_ring", int'(bus.ring),       1);
    check("s5_cnt",  int'(bus.snooze_cnt), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("s5_rst_ring",     int'(bus.ring),       0);
    check("s5_rst_snoozing", int'(bus.snoozing),   0);
    check("s5_rst_missed",   int'(bus.missed),     0);
    check("s5_rst_cnt",      int'(bus.snooze_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    // match still high at release: one trigger on the first edge
    @(negedge clk);
    check("s5_release_trig", int'(bus.ring), 1);
    pulse(1'b0, 1'b0, 1'b1);
    check("s5_stop", int'(bus.ring), 0);
    bus.match = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
